// File: rtl/axis_audio_pkg.sv
// Shared types and constants for the stereo AXI-Stream audio blocks.
package axis_audio_pkg;

   localparam int unsigned SAMPLE_W   = 24;
   localparam int unsigned UNITY_GAIN = 128;
   // Number of fractional gain bits (Q1.7 when unity is 128).
   localparam int unsigned GAIN_FRAC  = $clog2(UNITY_GAIN);

   localparam logic signed [SAMPLE_W-1:0] SAMPLE_MAX = 24'sh7F_FFFF;
   localparam logic signed [SAMPLE_W-1:0] SAMPLE_MIN = 24'sh80_0000;

   typedef enum logic [2:0] {
      StRxL,
      StRxR,
      StMult,
      StSat,
      StTxL,
      StTxR
   } vol_state_e;

endpackage

// File: rtl/gain_sat_channel.sv
// One audio channel: signed sample times unsigned gain, rescale by the gain's
// fractional bits, and saturate back to the sample range.
module gain_sat_channel
   import axis_audio_pkg::*;
#(
   parameter int unsigned GAIN_W = 8
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                mult_en_i,
   input  logic                sat_en_i,
   input  logic [SAMPLE_W-1:0] sample_i,
   input  logic [GAIN_W-1:0]   gain_i,
   output logic [SAMPLE_W-1:0] result_o,
   output logic                sat_o
);

   // Full-precision product: signed sample times zero-extended gain.
   localparam int unsigned ProdW = SAMPLE_W + GAIN_W + 1;

   logic signed [ProdW-1:0] sample_ext;
   logic signed [ProdW-1:0] gain_ext;
   logic signed [ProdW-1:0] product_d, product_q;
   logic signed [ProdW-1:0] shifted;
   logic signed [ProdW-1:0] max_ext, min_ext;
   logic                    sat_hi, sat_lo;
   logic [SAMPLE_W-1:0]     result_d, result_q;

   assign sample_ext = {{(GAIN_W + 1){sample_i[SAMPLE_W-1]}}, sample_i};
   assign gain_ext   = {{(SAMPLE_W + 1){1'b0}}, gain_i};
   assign max_ext    = {{(ProdW - SAMPLE_W){SAMPLE_MAX[SAMPLE_W-1]}}, SAMPLE_MAX};
   assign min_ext    = {{(ProdW - SAMPLE_W){SAMPLE_MIN[SAMPLE_W-1]}}, SAMPLE_MIN};

   // Product and saturated rescale of the registered product.
   always_comb begin
      product_d = sample_ext * gain_ext;
      shifted   = product_q >>> GAIN_FRAC;
      sat_hi    = (shifted > max_ext);
      sat_lo    = (shifted < min_ext);
      result_d  = shifted[SAMPLE_W-1:0];
      if (sat_hi) begin
         result_d = SAMPLE_MAX;
      end else if (sat_lo) begin
         result_d = SAMPLE_MIN;
      end
   end

   // Product captured in the multiply step, result in the saturate step.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         product_q <= '0;
         result_q  <= '0;
      end else begin
         if (mult_en_i) begin
            product_q <= product_d;
         end
         if (sat_en_i) begin
            result_q <= result_d;
         end
      end
   end

   assign result_o = result_q;
   assign sat_o    = sat_hi | sat_lo;

endmodule

// File: rtl/axis_volume_ctrl.sv
// Stereo AXI-Stream volume control: collects a left/right packet, scales both
// channels by per-channel gains that ramp one step per packet, and sends the
// packet back out in the same two-word format.
module axis_volume_ctrl
   import axis_audio_pkg::*;
#(
   parameter int unsigned GAIN_W = 8
) (
   input  logic              axis_clk,
   input  logic              axis_resetn,
   input  logic [31:0]       s_axis_data,
   input  logic              s_axis_valid,
   output logic              s_axis_ready,
   input  logic              s_axis_last,
   output logic [31:0]       m_axis_data,
   output logic              m_axis_valid,
   input  logic              m_axis_ready,
   output logic              m_axis_last,
   input  logic [GAIN_W-1:0] gain_l,
   input  logic [GAIN_W-1:0] gain_r,
   input  logic              mute,
   output logic              clip,
   output logic              frame_err
);

   vol_state_e          state_q, state_d;
   logic [SAMPLE_W-1:0] sample_l_q, sample_l_d;
   logic [SAMPLE_W-1:0] sample_r_q, sample_r_d;
   logic [GAIN_W-1:0]   gain_l_q, gain_l_d;
   logic [GAIN_W-1:0]   gain_r_q, gain_r_d;
   logic [GAIN_W-1:0]   target_l, target_r;
   logic                ready_q, ready_d;
   logic                valid_q, valid_d;
   logic                last_q, last_d;
   logic                clip_q, clip_d;
   logic                frame_err_q, frame_err_d;
   logic                rx_hs, tx_hs;
   logic [SAMPLE_W-1:0] result_l, result_r;
   logic                sat_l, sat_r;
   logic                unused_data;

   // Upper byte of each input word carries no audio.
   assign unused_data = ^s_axis_data[31:SAMPLE_W];

   assign rx_hs    = s_axis_valid & ready_q;
   assign tx_hs    = m_axis_ready & valid_q;
   assign target_l = mute ? '0 : gain_l;
   assign target_r = mute ? '0 : gain_r;

   // One unit toward the target; never leaves the range spanned by cur and tgt.
   function automatic logic [GAIN_W-1:0] ramp_step(input logic [GAIN_W-1:0] cur,
                                                   input logic [GAIN_W-1:0] tgt);
      logic [GAIN_W-1:0] nxt;
      nxt = cur;
      if (cur < tgt) begin
         nxt = cur + GAIN_W'(1);
      end else if (cur > tgt) begin
         nxt = cur - GAIN_W'(1);
      end
      return nxt;
   endfunction

   // Next-state, sample capture, gain ramp and registered output decode.
   always_comb begin
      state_d     = state_q;
      sample_l_d  = sample_l_q;
      sample_r_d  = sample_r_q;
      gain_l_d    = gain_l_q;
      gain_r_d    = gain_r_q;
      frame_err_d = 1'b0;
      clip_d      = 1'b0;
      case (state_q)
         StRxL: begin
            if (rx_hs) begin
               if (!s_axis_last) begin
                  sample_l_d = s_axis_data[SAMPLE_W-1:0];
                  state_d    = StRxR;
               end else begin
                  frame_err_d = 1'b1;
               end
            end
         end
         StRxR: begin
            if (rx_hs) begin
               if (s_axis_last) begin
                  sample_r_d = s_axis_data[SAMPLE_W-1:0];
                  state_d    = StMult;
               end else begin
                  // A second left word replaces the first one.
                  sample_l_d  = s_axis_data[SAMPLE_W-1:0];
                  frame_err_d = 1'b1;
               end
            end
         end
         StMult: state_d = StSat;
         StSat: begin
            clip_d  = sat_l | sat_r;
            state_d = StTxL;
         end
         StTxL: begin
            if (tx_hs) begin
               state_d = StTxR;
            end
         end
         StTxR: begin
            if (tx_hs) begin
               gain_l_d = ramp_step(gain_l_q, target_l);
               gain_r_d = ramp_step(gain_r_q, target_r);
               state_d  = StRxL;
            end
         end
         default: state_d = StRxL;
      endcase
      // Handshake flags follow the state being entered, so they register cleanly.
      ready_d = (state_d == StRxL) || (state_d == StRxR);
      valid_d = (state_d == StTxL) || (state_d == StTxR);
      last_d  = (state_d == StTxR);
   end

   // State and datapath registers, all cleared by reset.
   always_ff @(posedge axis_clk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         state_q     <= StRxL;
         sample_l_q  <= '0;
         sample_r_q  <= '0;
         gain_l_q    <= '0;
         gain_r_q    <= '0;
         ready_q     <= 1'b0;
         valid_q     <= 1'b0;
         last_q      <= 1'b0;
         clip_q      <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sample_l_q  <= sample_l_d;
         sample_r_q  <= sample_r_d;
         gain_l_q    <= gain_l_d;
         gain_r_q    <= gain_r_d;
         ready_q     <= ready_d;
         valid_q     <= valid_d;
         last_q      <= last_d;
         clip_q      <= clip_d;
         frame_err_q <= frame_err_d;
      end
   end

   gain_sat_channel #(
      .GAIN_W (GAIN_W)
   ) u_chan_l (
      .clk_i     (axis_clk),
      .rst_ni    (axis_resetn),
      .mult_en_i (state_q == StMult),
      .sat_en_i  (state_q == StSat),
      .sample_i  (sample_l_q),
      .gain_i    (gain_l_q),
      .result_o  (result_l),
      .sat_o     (sat_l)
   );

   gain_sat_channel #(
      .GAIN_W (GAIN_W)
   ) u_chan_r (
      .clk_i     (axis_clk),
      .rst_ni    (axis_resetn),
      .mult_en_i (state_q == StMult),
      .sat_en_i  (state_q == StSat),
      .sample_i  (sample_r_q),
      .gain_i    (gain_r_q),
      .result_o  (result_r),
      .sat_o     (sat_r)
   );

   assign s_axis_ready = ready_q;
   assign m_axis_valid = valid_q;
   assign m_axis_last  = last_q;
   assign m_axis_data  = {{(32 - SAMPLE_W){1'b0}}, (last_q ? result_r : result_l)};
   assign clip         = clip_q;
   assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_axis_volume_ctrl.sv
// Self-checking bench for axis_volume_ctrl: directed scenarios with random
// fill packets, checked against an arithmetic model of gain, ramp and clipping.
module tb_axis_volume_ctrl;

   logic        axis_clk = 1'b0;
   logic        axis_resetn = 1'b1;
   logic [31:0] s_axis_data = '0;
   logic        s_axis_valid = 1'b0;
   logic        s_axis_ready;
   logic        s_axis_last = 1'b0;
   logic [31:0] m_axis_data;
   logic        m_axis_valid;
   logic        m_axis_ready = 1'b1;
   logic        m_axis_last;
   logic [7:0]  gain_l = '0;
   logic [7:0]  gain_r = '0;
   logic        mute = 1'b0;
   logic        clip;
   logic        frame_err;

   int tests = 0;
   int fails = 0;
   int clip_cnt = 0;
   int fe_cnt = 0;
   int gl_m = 0;
   int gr_m = 0;

   axis_volume_ctrl #(
      .GAIN_W (8)
   ) dut (
      .axis_clk     (axis_clk),
      .axis_resetn  (axis_resetn),
      .s_axis_data  (s_axis_data),
      .s_axis_valid (s_axis_valid),
      .s_axis_ready (s_axis_ready),
      .s_axis_last  (s_axis_last),
      .m_axis_data  (m_axis_data),
      .m_axis_valid (m_axis_valid),
      .m_axis_ready (m_axis_ready),
      .m_axis_last  (m_axis_last),
      .gain_l       (gain_l),
      .gain_r       (gain_r),
      .mute         (mute),
      .clip         (clip),
      .frame_err    (frame_err)
   );

   always #22 axis_clk = ~axis_clk;

   always @(posedge axis_clk) begin
      if (clip) clip_cnt <= clip_cnt + 1;
      if (frame_err) fe_cnt <= fe_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: floor(sample * gain / 128), clamped to the 24-bit signed range.
   function automatic logic [23:0] chan_ref(input logic [23:0] smp, input int g,
                                            output bit sat);
      longint p, q;
      p = longint'($signed(smp)) * longint'(g);
      q = p / 128;
      if ((p % 128 != 0) && (p < 0)) q = q - 1;
      sat = 1'b0;
      if (q > 8388607) begin
         q = 8388607;
         sat = 1'b1;
      end else if (q < -8388608) begin
         q = -8388608;
         sat = 1'b1;
      end
      return q[23:0];
   endfunction

   task automatic model_step();
      int tl, tr;
      tl = mute ? 0 : int'(gain_l);
      tr = mute ? 0 : int'(gain_r);
      if (gl_m < tl) gl_m++; else if (gl_m > tl) gl_m--;
      if (gr_m < tr) gr_m++; else if (gr_m > tr) gr_m--;
   endtask

   // Called at a negedge; returns at the negedge after the handshake edge.
   task automatic send_word(input logic [23:0] smp, input logic last, input string tag);
      int n;
      logic [7:0] junk;
      junk = 8'($urandom());
      s_axis_data  = {junk, smp};
      s_axis_last  = last;
      s_axis_valid = 1'b1;
      n = 0;
      while (!s_axis_ready && n < 100) begin
         @(negedge axis_clk);
         n++;
      end
      check({tag, " input accepted"}, 32'(n < 100), 32'd1);
      @(negedge axis_clk);
      s_axis_valid = 1'b0;
   endtask

   // Called right after the right-word handshake; checks the output packet.
   task automatic expect_out(input logic [23:0] l, input logic [23:0] r, input string tag,
                             input int stall);
      logic [23:0] el, er;
      logic [31:0] held;
      bit cl, cr;
      int n, clip0;
      el = chan_ref(l, gl_m, cl);
      er = chan_ref(r, gr_m, cr);
      clip0 = clip_cnt;
      if (stall > 0) m_axis_ready = 1'b0;
      n = 0;
      while (!m_axis_valid && n < 20) begin
         @(negedge axis_clk);
         n++;
      end
      check({tag, " latency"}, 32'(n), 32'd2);
      held = m_axis_data;
      for (int i = 0; i < stall; i++) begin
         @(negedge axis_clk);
         check({tag, " stall data"}, m_axis_data, held);
         check({tag, " stall valid"}, 32'(m_axis_valid), 32'd1);
         check({tag, " stall s_ready"}, 32'(s_axis_ready), 32'd0);
      end
      m_axis_ready = 1'b1;
      check({tag, " L data"}, m_axis_data, {8'h00, el});
      check({tag, " L last"}, 32'(m_axis_last), 32'd0);
      @(negedge axis_clk);
      check({tag, " R valid"}, 32'(m_axis_valid), 32'd1);
      check({tag, " R data"}, m_axis_data, {8'h00, er});
      check({tag, " R last"}, 32'(m_axis_last), 32'd1);
      @(negedge axis_clk);
      check({tag, " clip pulses"}, 32'(clip_cnt - clip0), 32'(cl | cr));
      check({tag, " idle after"}, 32'(m_axis_valid), 32'd0);
      model_step();
   endtask

   task automatic run_packet(input logic [23:0] l, input logic [23:0] r, input string tag,
                             input int stall);
      send_word(l, 1'b0, tag);
      send_word(r, 1'b1, tag);
      expect_out(l, r, tag, stall);
   endtask

   task automatic run_random(input int count, input string tag);
      for (int i = 0; i < count; i++) begin
         run_packet(24'($urandom()), 24'($urandom()), tag, 0);
      end
   endtask

   initial begin
      int fe0;
      logic [23:0] l2;

      // Reset values
      #5 axis_resetn = 1'b0;
      #5;
      check("reset s_ready", 32'(s_axis_ready), 32'd0);
      check("reset m_valid", 32'(m_axis_valid), 32'd0);
      check("reset m_last", 32'(m_axis_last), 32'd0);
      check("reset m_data", m_axis_data, 32'd0);
      check("reset clip", 32'(clip), 32'd0);
      check("reset frame_err", 32'(frame_err), 32'd0);
      repeat (3) @(negedge axis_clk);
      axis_resetn = 1'b1;
      @(negedge axis_clk);
      check("post-reset s_ready", 32'(s_axis_ready), 32'd1);

      // Unity gain: ramp up from zero, then the directed pair
      gain_l = 8'd128;
      gain_r = 8'd128;
      run_random(130, "ramp128");
      run_packet(24'h100000, 24'hF00000, "unity", 0);

      // Maximum gain: both channels saturate, one clip pulse
      gain_l = 8'd255;
      gain_r = 8'd255;
      run_random(127, "ramp255");
      run_packet(24'h7FFFFF, 24'h800000, "gain255 clip", 0);

      // Half gain: rounding toward minus infinity
      gain_l = 8'd64;
      gain_r = 8'd64;
      run_random(191, "ramp64");
      run_packet(24'hFFFFFF, 24'h000003, "gain64", 0);

      // Mute ramps down by one per packet
      gain_l = 8'd128;
      gain_r = 8'd128;
      run_random(64, "settle128");
      mute = 1'b1;
      for (int i = 0; i < 128; i++) begin
         run_packet(24'h400000, 24'hC00000, "mute ramp", 0);
      end
      run_packet(24'h7FFFFF, 24'h800000, "muted", 0);
      mute = 1'b0;
      run_random(20, "unmute");

      // Output back-pressure in TX_L
      run_packet(24'h123456, 24'hABCDEF, "stall", 10);

      // Right-marked word in RX_L is dropped with an error pulse
      fe0 = fe_cnt;
      send_word(24'h55AA55, 1'b1, "stray right");
      repeat (6) begin
         @(negedge axis_clk);
         check("stray no output", 32'(m_axis_valid), 32'd0);
      end
      check("stray frame_err", 32'(fe_cnt - fe0), 32'd1);

      // Second left word overwrites the first
      fe0 = fe_cnt;
      l2 = 24'($urandom());
      send_word(24'h111111, 1'b0, "dup left a");
      send_word(l2, 1'b0, "dup left b");
      send_word(24'h2A2A2A, 1'b1, "dup right");
      expect_out(l2, 24'h2A2A2A, "overwrite", 0);
      check("overwrite frame_err", 32'(fe_cnt - fe0), 32'd1);

      // Reset while waiting for the right word discards the partial packet
      gain_l = 8'd200;
      gain_r = 8'd200;
      send_word(24'h3C3C3C, 1'b0, "partial");
      axis_resetn = 1'b0;
      gl_m = 0;
      gr_m = 0;
      #5;
      check("mid reset s_ready", 32'(s_axis_ready), 32'd0);
      check("mid reset m_valid", 32'(m_axis_valid), 32'd0);
      @(negedge axis_clk);
      axis_resetn = 1'b1;
      @(negedge axis_clk);
      fe0 = fe_cnt;
      run_random(40, "after reset");
      check("after reset frame_err", 32'(fe_cnt - fe0), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Overall time limit so a stuck handshake cannot hang the run.
   initial begin
      #20ms;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
